// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding, parameter
// defaults and the round-robin pointer wrap helper.
package uart_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int LOCK_MAX_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_DONE = 3'd2,
    RELEASE   = 3'd3,
    HOLD      = 3'd4
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping past N_REQ-1 back to 0; returns one-hot winner and its index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    vld      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k fits in one extra bit since both are below N_REQ
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ))
        cand = cand - (IDX_W + 1)'(N_REQ);
      cand_idx = cand[IDX_W-1:0];
      if (!vld && req[cand_idx]) begin
        vld           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Optional burst lock (lock port, HOLD state, burst counter) under UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
`ifdef UART_ARB_LOCK_EN
  , parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     lock,
`endif
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] gnt_q, ack_q;
  logic [IDX_W-1:0] owner, rr_ptr;
  logic [7:0]       byte_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  logic load_grant, load_hold, do_ack, do_release, hold_ok;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef UART_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] burst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      burst_cnt <= '0;
    else if (do_release)
      burst_cnt <= '0;
    else if (do_ack)
      burst_cnt <= burst_cnt + 1'b1;
  end

  // Hold only while the byte just finished still leaves room in the burst
  assign hold_ok = lock[owner] && (burst_cnt < CNT_W'(LOCK_MAX - 1));
`else
  assign hold_ok = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    load_grant = 1'b0;
    load_hold  = 1'b0;
    do_ack     = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !tx_active) begin
          load_grant = 1'b1;
          state_nxt  = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          do_ack    = 1'b1;
          state_nxt = hold_ok ? HOLD : RELEASE;
        end
      end
      RELEASE: begin
        do_release = 1'b1;
        state_nxt  = IDLE;
      end
`ifdef UART_ARB_LOCK_EN
      HOLD: begin
        if (!lock[owner]) begin
          state_nxt = RELEASE;
        end else if (req[owner] && !tx_active) begin
          load_hold = 1'b1;
          state_nxt = LAUNCH;
        end
      end
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      ack_q  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      byte_q <= 8'h00;
    end else begin
      state <= state_nxt;
      ack_q <= do_ack ? gnt_q : '0;
      if (load_grant) begin
        gnt_q  <= pick_oh;
        owner  <= pick_idx;
        byte_q <= req_data[{pick_idx, 3'b000} +: 8];
      end
      if (load_hold)
        byte_q <= req_data[{owner, 3'b000} +: 8];
      // Clearing the byte here leaves every output low once back in IDLE
      if (do_release) begin
        gnt_q  <= '0;
        byte_q <= 8'h00;
        rr_ptr <= IDX_W'(wrap_inc(int'(owner), N_REQ));
      end
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign tx_byte  = byte_q;
  assign tx_start = (state == LAUNCH);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx stand-in
// and a transaction-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]   lock = '0;
`endif
  logic [N-1:0]   gnt, ack;
  logic           tx_start, busy;
  logic [7:0]     tx_byte;
  logic           tx_active, tx_done;

  logic u_act, u_done;
  logic inj_done = 1'b0;
  int   u_cnt;
  int   frame_len = 12;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] dat [N];
  int   m_ptr = 0;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .ack       (ack),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy for frame_len cycles after tx_start, one-cycle done
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_act  <= 1'b0;
      u_done <= 1'b0;
      u_cnt  <= 0;
    end else begin
      u_done <= 1'b0;
      if (u_done)
        u_act <= 1'b0;
      else if (tx_start && !u_act) begin
        u_act <= 1'b1;
        u_cnt <= frame_len;
      end else if (u_act && u_cnt > 0) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) u_done <= 1'b1;
      end
    end
  end
  assign tx_active = u_act;
  assign tx_done   = u_done | inj_done;

  function automatic int rr_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if ((r & (N'(1) << ((p + k) % N))) != '0) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    inj_done = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Runs one frame: returns what was seen at tx_start, at tx_done and one cycle later.
  task automatic wait_txn(input logic [N-1:0] drop, output bit ok, output int t_s,
                          output logic [N-1:0] g_s, output logic [7:0] b_s,
                          output int t_d, output logic [7:0] b_d, output logic [N-1:0] a);
    ok = 1'b0; t_s = 0; g_s = '0; b_s = '0; t_d = 0; b_d = '0; a = '0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1'b1; t_s = cyc; g_s = gnt; b_s = tx_byte; end
    end
    if (!ok) return;
    @(negedge clk);
    req = req & ~drop;
    for (int i = 0; i < N; i++)
      if ((g_s & onehot(i)) != '0) req_data[8*i +: 8] = ~dat[i];
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (tx_done) begin ok = 1'b1; t_d = cyc; b_d = tx_byte; end
    end
    if (!ok) return;
    @(negedge clk);
    a = ack;
  endtask

  task automatic test_reset();
    logic [N-1:0] g_acc;
    logic         b_acc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_chk++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_chk++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", tx_start); end
    n_chk++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", tx_byte); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    g_acc = '0; b_acc = 1'b0;
    repeat (6) begin
      @(negedge clk);
      g_acc = g_acc | gnt | ack;
      b_acc = b_acc | busy | tx_start;
    end
    n_chk++; if ({g_acc, b_acc} !== '0) begin n_fail++; $display("FAIL idle_quiet: got gnt|ack=%b busy|start=%b want 0", g_acc, b_acc); end
  endtask

  task automatic test_single();
    bit ok; int ts, td; logic [N-1:0] g, a; logic [7:0] bs, bd;
    logic [9:0] fr, want;
    int bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    do_reset();
    frame_len = 20;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    dat[2] = 8'hA5;
    drive();
    req = 4'b0100;
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no frame want one"); return; end
    n_chk++; if (g !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", g); end
    n_chk++; if (bs !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %h want a5", bs); end
    fr = {1'b1, bs, 1'b0};
    for (int k = 0; k < 10; k++) want[k] = (bits[k] != 0);
    n_chk++; if (fr !== want) begin n_fail++; $display("FAIL single_frame: got %b want %b", fr, want); end
    n_chk++; if (bd !== 8'hA5) begin n_fail++; $display("FAIL single_byte_stable: got %h want a5", bd); end
    n_chk++; if (a !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", a); end
    req = '0;
    @(negedge clk);
    n_chk++; if (ack !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", ack); end
  endtask

  task automatic test_round_robin();
    bit ok; int ts, td, prev_d; logic [N-1:0] g, a; logic [7:0] bs, bd;
    int exp;
    do_reset();
    frame_len = int'($urandom_range(4, 15));
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    drive();
    req = '1;
    prev_d = -1;
    for (int t = 0; t < 5; t++) begin
      exp = t % N;
      wait_txn('0, ok, ts, g, bs, td, bd, a);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got no frame want frame %0d", t); return; end
      n_chk++; if (g !== onehot(exp)) begin n_fail++; $display("FAIL rr_gnt: got %b want %b", g, onehot(exp)); end
      n_chk++; if (bs !== dat[exp]) begin n_fail++; $display("FAIL rr_byte: got %h want %h", bs, dat[exp]); end
      n_chk++; if (a !== onehot(exp)) begin n_fail++; $display("FAIL rr_ack: got %b want %b", a, onehot(exp)); end
      if (prev_d >= 0) begin
        n_chk++; if (ts - prev_d != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d want 3", ts - prev_d); end
      end
      prev_d = td;
      dat[exp] = 8'($urandom);
      drive();
    end
    req = '0;
  endtask

  task automatic test_drop();
    bit ok; int ts, td; logic [N-1:0] g, a; logic [7:0] bs, bd;
    do_reset();
    frame_len = 10;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    drive();
    req = 4'b0001;
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    req = 4'b1111;
    drive();
    wait_txn(4'b0010, ok, ts, g, bs, td, bd, a);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL drop_timeout: got no frame want one"); return; end
    n_chk++; if (g !== 4'b0010) begin n_fail++; $display("FAIL drop_gnt: got %b want 0010", g); end
    n_chk++; if (bd !== dat[1]) begin n_fail++; $display("FAIL drop_byte: got %h want %h", bd, dat[1]); end
    n_chk++; if (a !== 4'b0010) begin n_fail++; $display("FAIL drop_ack: got %b want 0010", a); end
    drive();
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    n_chk++; if (g !== 4'b0100) begin n_fail++; $display("FAIL drop_next: got %b want 0100", g); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit ok; int ts, td; logic [N-1:0] g, a; logic [7:0] bs, bd;
    logic seen;
    do_reset();
    frame_len = 8;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom) | 8'h01;
    drive();
    req = 4'b0010;
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    req = 4'b1000;
    frame_len = 3910;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = tx_start;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no start want one"); return; end
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({gnt, ack, tx_start, tx_byte, busy} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got gnt=%b ack=%b start=%b byte=%h busy=%b want 0", gnt, ack, tx_start, tx_byte, busy);
    end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    frame_len = 8;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | (|ack) | busy;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_noack: got %b want 0", seen); end
    req = '1;
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    n_chk++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b want 0001", g); end
    req = '0;
  endtask

  task automatic test_idle_done();
    logic seen;
    do_reset();
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|ack) | (|gnt) | busy | tx_start;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_done: got activity=%b want 0", seen); end
  endtask

  task automatic test_random();
    bit ok; int ts, td, exp; logic [N-1:0] g, a; logic [7:0] bs, bd;
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    drive();
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int t = 0; t < 40; t++) begin
      frame_len = int'($urandom_range(4, 20));
      exp = rr_win(req, m_ptr);
      wait_txn('0, ok, ts, g, bs, td, bd, a);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got no frame want one at %0d", t); return; end
      n_chk++; if (g !== onehot(exp) || bs !== dat[exp] || bd !== dat[exp] || a !== onehot(exp)) begin
        n_fail++; $display("FAIL rand_txn%0d: got gnt=%b byte=%h/%h ack=%b want gnt=%b byte=%h", t, g, bs, bd, a, onehot(exp), dat[exp]);
      end
      m_ptr = (exp + 1) % N;
      dat[exp] = 8'($urandom);
      req = req | N'($urandom);
      if ($urandom_range(0, 1) == 0) req = req & ~onehot(exp);
      if (req == '0) req = onehot(int'($urandom_range(0, N - 1)));
      drive();
    end
    req = '0;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    bit ok; int ts, td; logic [N-1:0] g, a; logic [7:0] bs, bd;
    do_reset();
    frame_len = 6;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    drive();
    lock = 4'b1000;
    req = 4'b1001;
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    n_chk++; if (g !== 4'b0001) begin n_fail++; $display("FAIL lock_first: got %b want 0001", g); end
    dat[0] = 8'($urandom);
    drive();
    for (int t = 0; t < 16; t++) begin
      wait_txn('0, ok, ts, g, bs, td, bd, a);
      n_chk++; if (!ok || g !== 4'b1000 || bs !== dat[3]) begin
        n_fail++; $display("FAIL lock_burst%0d: got gnt=%b byte=%h want gnt=1000 byte=%h", t, g, bs, dat[3]);
      end
      dat[3] = 8'($urandom);
      drive();
    end
    wait_txn('0, ok, ts, g, bs, td, bd, a);
    n_chk++; if (g !== 4'b0001) begin n_fail++; $display("FAIL lock_release: got %b want 0001", g); end
    lock = '0;
    req = '0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_idle_done();
    test_random();
    test_reset_mid();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter LOCK_MAX, default 16: maximum bytes per locked burst (lock build only).
REQ-003 Port clk  in  1  single system clock, all logic on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port req  in  N_REQ  per-requester send request, level, held until ack.
REQ-006 Port req_data  in  8*N_REQ  byte per requester; slice i is bits [8i+7:8i].
REQ-007 Port lock  in  N_REQ  burst-hold request (lock build only; otherwise absent).
REQ-008 Port gnt  out  N_REQ  one-hot grant, registered.
REQ-009 Port ack  out  N_REQ  one-cycle pulse when the granted byte has finished transmitting.
REQ-010 Port tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-011 Port tx_byte  out  8  byte to uart_tx, stable from tx_start until tx_done.
REQ-012 Port tx_active  in  1  uart_tx busy flag.
REQ-013 Port tx_done  in  1  uart_tx one-cycle frame-complete pulse.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE, RELEASE (plus HOLD in lock build).
REQ-016 IDLE: if any req bit is high and tx_active is low, the block SHALL pick a winner round-robin starting at index rr_ptr, set gnt, latch req_data slice into tx_byte, and go to LAUNCH next cycle.
REQ-017 LAUNCH: tx_start SHALL be high for exactly this one cycle; next state WAIT_DONE.
REQ-018 WAIT_DONE: the FSM SHALL stay until tx_done=1; in that cycle it SHALL pulse ack[owner] (registered, visible next cycle) and go to RELEASE.
REQ-019 RELEASE: gnt SHALL clear, rr_ptr SHALL become (owner+1) mod N_REQ, next state IDLE; this one-cycle gap covers uart_tx's post-done recovery cycle.
REQ-020 Minimum spacing from tx_done to the next tx_start SHALL be 3 cycles (RELEASE, IDLE, LAUNCH).
REQ-021 req dropping after grant SHALL NOT abort the frame; the byte completes and ack still pulses.
REQ-022 req_data changes after grant SHALL NOT affect tx_byte.
REQ-023 tx_done outside WAIT_DONE SHALL be ignored.
REQ-024 The rr_ptr wrap from N_REQ-1 to 0 SHALL be handled with no skipped requester.
REQ-025 With no req high, the FSM SHALL remain in IDLE with all outputs low.

Reset
REQ-026 On rst: state IDLE, rr_ptr 0, gnt 0, ack 0, tx_start 0, tx_byte 8'h00, busy 0, burst count 0.
REQ-027 Reset mid-frame SHALL drop the grant immediately with no ack; a uart_tx reset together with the arbiter is required.

Configuration
REQ-028 Macro UART_ARB_LOCK_EN: when defined, lock port, HOLD state and burst counter are compiled in.
REQ-029 With the macro defined and lock[owner]=1 at tx_done, the FSM SHALL keep gnt, skip rr_ptr advance, go to HOLD; HOLD relaunches with a new latched byte when req[owner]=1 and tx_active=0, and goes to RELEASE when lock[owner]=0.
REQ-030 A burst reaching LOCK_MAX bytes SHALL force RELEASE regardless of lock.
REQ-031 Without the macro, behaviour SHALL be exactly REQ-015..025 with no lock port.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state encoding and the LOCK_MAX and N_REQ defaults.
REQ-033 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs req and ptr, output one-hot winner plus index.

Verification (uart_tx at baud_rate=391, frame = 3910 cycles)
REQ-034 A single req[2] with data 8'hA5 -> gnt=4'b0100, tx_start pulse, serial frame 0,1,0,1,0,0,1,0,1,1 (LSB first), then ack[2] pulse.
REQ-035 req=4'b1111 held -> grant order 0,1,2,3,0; each tx_start exactly 3 cycles after the prior tx_done.
REQ-036 req[1] dropped mid-frame -> frame completes, ack[1] pulses, next grant goes to index 2.
REQ-037 rst asserted 1000 cycles into a frame -> all outputs 0 next edge, rr_ptr 0, no ack.
REQ-038 UART_ARB_LOCK_EN with lock[3]=1 and req=4'b1001 -> 16 consecutive bytes to requester 3, then forced release and grant to 0.
REQ-039 A tx_done pulse injected while in IDLE -> no ack and no state change.
